decode_arbiter: RTL



---
 rtl/decode_arbiter_if.sv | 27 ++
 rtl/decode_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decode_arbiter_if.sv
// rtl/decode_arbiter_if.sv - request/grant bundle between the requesters and the decode arbiter
interface decode_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] addr;
    logic       gnt_vld;
    logic [7:0] sel_n;
    logic       timeout;

    modport master (
        input  req,
        input  done,
        output addr,
        output gnt_vld,
        output sel_n,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  addr,
        input  gnt_vld,
        input  sel_n,
        input  timeout
    );
endinterface

// File: rtl/decode_arbiter.sv
// rtl/decode_arbiter.sv - round-robin owner of the 8-way decoded select bus with hold limit
module decode_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CW       = 4
) (
    input logic             clk,
    input logic             rst,
    decode_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [2:0]    addr_q, addr_d;
    logic [2:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic [7:0]    sel_q, sel_d;
    logic          to_q, to_d;

    logic [15:0]   req_dbl;
    logic [3:0]    rot_shift;
    logic [7:0]    req_rot;
    logic [2:0]    win_off;
    logic [2:0]    win_idx;
    logic          win_any;
    logic          rel_soft;
    logic          rel_hold;

    // Rotate so that bit 0 is the requester right after the last owner,
    // then the lowest set bit is the round-robin winner.
    always_comb begin
        req_dbl   = {bus.req, bus.req};
        rot_shift = {1'b0, last_q} + 4'd1;
        req_rot   = 8'(req_dbl >> rot_shift);
        win_off   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
        win_idx = last_q + 3'd1 + win_off;
        win_any = |bus.req;
    end

    assign rel_soft = bus.done | ~bus.req[addr_q];
    assign rel_hold = (cnt_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 3'd0;
            last_q  <= 3'd7;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            sel_q   <= 8'hFF;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_soft || rel_hold) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = win_any ? GRANT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; the dead cycle falls out of
    // GRANT always leaving through RELEASE.
    always_comb begin
        addr_d = addr_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        gnt_d  = 1'b0;
        sel_d  = 8'hFF;
        to_d   = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (win_any) begin
                    addr_d = win_idx;
                    last_d = win_idx;
                    cnt_d  = '0;
                    gnt_d  = 1'b1;
                    sel_d  = ~(8'h01 << win_idx);
                end
            end
            GRANT: begin
                if (rel_soft || rel_hold) begin
                    to_d = ~rel_soft;
                end else begin
                    gnt_d = 1'b1;
                    sel_d = sel_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d = 1'b0;
            end
        endcase
    end

    assign bus.addr    = addr_q;
    assign bus.gnt_vld = gnt_q;
    assign bus.sel_n   = sel_q;
    assign bus.timeout = to_q;

endmodule
